rr_arbiter_4: RTL

Four-requester arbiter that shares a single downstream resource among requesters, using the team's 4:2 priority-encoding order (bit 3 highest) as its fixed-priority mode and a rotating variant for fairness. A requester holds `req` high for as long as it needs the resource and releases it by dropping `req`. Grants are registered, one-hot, and separated by a mandatory one-cycle bubble. In round-robin mode an optional hold limit preempts a long-running owner. It sits between the requester ports and the shared datapath mux select.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_pick_4.sv | 33 +++
 rtl/rr_arbiter_4.sv | 116 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester arbiter.
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int HOLD_W = 4;

  // Hold counter saturation value
  localparam logic [HOLD_W-1:0] HOLD_SAT = 4'd15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Binary requester index to one-hot grant vector
  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority picker. Candidates are scanned in the order
// last_id-1, last_id-2, last_id-3, last_id (mod 4), so the previous winner is
// always considered last. With rr_en low the base is pinned to 0, which gives
// the plain 3 > 2 > 1 > 0 encoder order.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  input  logic             rr_en,
  output logic [ID_W-1:0]  win_id,
  output logic             win_valid
);

  logic [ID_W-1:0] base;
  logic [ID_W-1:0] cand;

  // Scan candidates in rotating order and keep the first one requesting
  always_comb begin
    base      = rr_en ? last_id : '0;
    cand      = '0;
    win_id    = '0;
    win_valid = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = base - ID_W'(k);
      if (!win_valid && req[cand]) begin
        win_id    = cand;
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester arbiter with registered one-hot grant and a mandatory
// one-cycle bubble between owners. In round-robin mode a long-running owner
// is preempted after HOLD_MAX grant cycles if anybody else is waiting.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no grant driven; a pending request is granted on next edge
//   GRANT | gnt = onehot(last_id); leaves on release or preemption
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter bit RR_EN    = 1'b1,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid
);

  // Terminal hold count: a grant entered with hold_cnt=0 has served
  // HOLD_MAX cycles when the counter reads HOLD_MAX-1.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              gnt_valid_q, gnt_valid_d;

  logic [ID_W-1:0]   win_id;
  logic              win_valid;
  logic [N_REQ-1:0]  owner_oh;
  logic              others_pending;
  logic              release_ev;
  logic              preempt_ev;

  rr_pick_4 u_pick (
    .req       (req),
    .last_id   (last_id_q),
    .rr_en     (RR_EN),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  // Exit conditions for the current owner; release wins ties, but both
  // lead to the same next state so no explicit ordering is needed.
  assign owner_oh       = id_to_onehot(last_id_q);
  assign others_pending = |(req & ~owner_oh);
  assign release_ev     = ~req[last_id_q];
  assign preempt_ev     = RR_EN && (hold_cnt_q == HOLD_LAST) && others_pending;

  // Next-state, pointer, hold counter and registered output values
  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = '0;
    gnt_id_d    = '0;
    gnt_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d     = GRANT;
          last_id_d   = win_id;
          hold_cnt_d  = '0;
          gnt_d       = id_to_onehot(win_id);
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if (release_ev || preempt_ev) begin
          state_d = IDLE;
        end else begin
          gnt_d       = owner_oh;
          gnt_id_d    = last_id_q;
          gnt_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_id_q   <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule
